seq_restoring_divider: RTL
==========================

# seq_restoring_divider

Multi-cycle unsigned restoring divider. It is the inverse companion of the ALU's combinational multiply path: it takes a 2*WIDTH-bit product-width dividend and a WIDTH-bit divisor, and returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder. It runs one quotient bit per clock under a start/busy/done handshake, and sits beside the ALU in the datapath.

## Interface
- WIDTH, 4, operand width; dividend and quotient are 2*WIDTH, divisor and remainder are WIDTH.
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request; sampled only in IDLE.
- i_dividend  input  2*WIDTH  unsigned dividend; captured on the accepting edge.
- i_divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
- o_busy  output  1  high while in CALC.
- o_done  output  1  one-cycle pulse; results are valid from this cycle onward.
- o_quotient  output  2*WIDTH  registered quotient.
- o_remainder  output  WIDTH  registered remainder.
- o_div_by_zero  output  1  registered; set with o_done when the captured divisor was 0.

## Operation
- Reset values:
  - State IDLE.
  - o_busy, o_done, o_div_by_zero = 0.
  - o_quotient, o_remainder = 0.
  - Iteration counter = 0.
- States: IDLE, CALC, DONE.
- IDLE, i_start=1 on edge E0: capture operands, clear the (WIDTH+1)-bit partial remainder, load the dividend into the shift register, set counter = 0, go to CALC.
- CALC, once per edge:
  - Form the trial value {partial_rem[WIDTH-1:0], dividend MSB}.
  - If trial >= divisor: partial_rem = trial - divisor and shift quotient bit 1 in.
  - Otherwise: partial_rem = trial and shift quotient bit 0 in.
  - Increment the counter. After the 2*WIDTH-th iteration, load o_quotient/o_remainder and go to DONE.
- DONE: o_done=1 for exactly one cycle, then unconditionally return to IDLE.
- Result registers hold their values until the next DONE or reset.
- i_start is ignored in CALC and DONE. There is no queueing, and a start during the DONE cycle is dropped.
- Arithmetic is unsigned. The quotient is 2*WIDTH wide, so no overflow is possible for a nonzero divisor.
- Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
- Zero divisor always gives o_quotient = all ones, o_remainder = i_dividend[WIDTH-1:0]. Latency and o_div_by_zero depend on configuration (see Configuration).
- Reset asserted mid-operation aborts immediately to IDLE with all outputs at their reset values. No partial result is exposed.

## Timing
- Accepting edge E0. o_busy is high for the cycles after edges E0 .. E0+2*WIDTH-1.
- o_done is high in the cycle after edge E0+2*WIDTH. Latency is 2*WIDTH cycles; 8 for WIDTH=4.
- Earliest next accepting edge is E0+2*WIDTH+2, so throughput is one operation per 2*WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - A zero divisor at E0 skips CALC and goes to DONE.
  - o_done follows in the cycle after E0+1, with o_div_by_zero=1 and the fixed zero-divisor results.
- DIV_ZERO_DETECT_EN undefined:
  - A zero divisor runs the full 2*WIDTH iterations and produces the same result values naturally.
  - o_div_by_zero is tied to 0.

## Structure
- Shared package holds:
  - The state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - The counter-width function clog2(2*WIDTH+1).
- Sub-module div_step (combinational, WIDTH parameter) implements one restoring iteration.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder and quotient bit.
  - It reuses subtractor_without_borrow_in on WIDTH+1 bits; the borrow-out selects restore.
- The top level holds the FSM, the counter, and the shift/result registers.

## Test plan
All scenarios use WIDTH=4.
- Dividend 8'd200, divisor 4'd7: o_done 8 cycles after acceptance, quotient 8'd28, remainder 4'd4, o_busy high for exactly 8 cycles.
- Divisor 4'd1 and 4'd15 boundaries:
  - 8'd255/1 gives q=255, r=0.
  - 8'd5/9 gives q=0, r=5.
  - 8'd255/15 gives q=17, r=0.
- Zero divisor, dividend 8'hA5: q=8'hFF, r=4'h5.
  - With DIV_ZERO_DETECT_EN: o_div_by_zero=1 and o_done 1 cycle after acceptance.
  - Without DIV_ZERO_DETECT_EN: o_div_by_zero=0 and o_done after 8 cycles.
- i_start held high and pulsed during CALC and DONE with new operands: only the first request completes. The result matches the first operands, and the next acceptance occurs no earlier than E0+10.
- i_rst_n pulsed low in the 4th CALC cycle: outputs drop to 0 asynchronously with no o_done. A fresh 8'd100/4'd3 then completes with q=33, r=1.
- 500 random operand pairs with nonzero divisor, compared against behavioural / and %: zero mismatches, and "!!!Test completed succesfully" is printed.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
// Shared state encodings and the counter-width helper for the restoring divider.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;
  logic           w_borrow;
  logic           w_unused_msb;

  // The restored remainder never exceeds WIDTH bits, so the top bit drops out of the shift.
  assign w_unused_msb = i_rem[WIDTH];
  assign w_trial      = {i_rem[WIDTH-1:0], i_bit};

  subtractor_without_borrow_in #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .i_a     (w_trial),
    .i_b     ({1'b0, i_divisor}),
    .o_diff  (w_diff),
    .o_borrow(w_borrow)
  );

  assign o_rem  = w_borrow ? w_trial : w_diff;
  assign o_qbit = ~w_borrow;

endmodule

// File: rtl/subtractor_without_borrow_in.sv
// Plain unsigned subtractor; the borrow-out flags a negative difference.
module subtractor_without_borrow_in #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional zero-divisor shortcut enabled by macro DIV_ZERO_DETECT_EN.
//
// state   | meaning
// IDLE    | waiting for i_start; operands captured on the accepting edge
// CALC    | one restoring iteration per clock, 2*WIDTH iterations
// DONE    | o_done pulse cycle, then back to IDLE
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [2*WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0]   o_remainder,
  output logic               o_div_by_zero
);

  localparam int DW    = 2 * WIDTH;
  localparam int CNT_W = clog2(DW + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_prem;
  logic [DW-1:0]    r_shift;
  logic [WIDTH-1:0] r_dsr;
  logic [DW-1:0]    r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH:0]   w_step_rem;
  logic             w_step_q;
  logic             w_accept;
  logic             w_last;
  logic             w_zero_skip;

  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_last   = (r_state == ST_CALC) && (r_cnt == CNT_LAST);

`ifdef DIV_ZERO_DETECT_EN
  assign w_zero_skip = w_accept && (i_divisor == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_prem),
    .i_bit    (r_shift[DW-1]),
    .i_divisor(r_dsr),
    .o_rem    (w_step_rem),
    .o_qbit   (w_step_q)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = w_zero_skip ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (r_cnt == CNT_LAST) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        // A zero-divisor shortcut lands here before its pulse; it lingers one cycle to raise it.
        if (r_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_CALC);
      r_done  <= w_last || ((r_state == ST_DONE) && !r_done);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_prem  <= '0;
      r_shift <= '0;
      r_dsr   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_prem  <= '0;
      r_shift <= i_dividend;
      r_dsr   <= i_divisor;
      if (w_zero_skip) begin
        r_quot <= '1;
        r_rem  <= i_dividend[WIDTH-1:0];
        r_dbz  <= 1'b1;
      end
    end else if (r_state == ST_CALC) begin
      // Quotient bits fill the shift register from the bottom as dividend bits leave the top.
      r_prem  <= w_step_rem;
      r_shift <= {r_shift[DW-2:0], w_step_q};
      r_cnt   <= r_cnt + CNT_ONE;
      if (w_last) begin
        r_quot <= {r_shift[DW-2:0], w_step_q};
        r_rem  <= w_step_rem[WIDTH-1:0];
        r_dbz  <= 1'b0;
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dbz;

endmodule
